// File: rtl/pc_stack_seq.sv
// Program sequencer: LFSR-stepped low PC, page register and a shift-style return stack.
// Latency: single cycle; an op sampled at a rising edge is visible on every output right after it.
// Backpressure: none; en=0 freezes all state, err_clr acts regardless of en.
module pc_stack_seq #(
  parameter int unsigned PL_W = 6,
  parameter int unsigned PU_W = 4,
  parameter logic [PL_W-1:0] TAPS = 6'b000011,
  parameter int unsigned DEPTH = 4,
  parameter logic [PU_W-1:0] CALL_PAGE = '1,
  parameter bit OVF_MODE = 1'b0,
  localparam int unsigned AW = PU_W + PL_W,
  localparam int unsigned SPW = $clog2(DEPTH + 1)
) (
  input  logic            CLK_main,
  input  logic            RESET,
  input  logic            en,
  input  logic [2:0]      op,
  input  logic [PL_W-1:0] tgt_pl,
  input  logic [PU_W-1:0] tgt_pu,
  input  logic            err_clr,
  output logic [AW-1:0]   pc,
  output logic [AW-1:0]   top,
  output logic [SPW-1:0]  sp_cnt,
  output logic            stk_ovf,
  output logic            stk_unf
);

  localparam logic [2:0] OP_NEXT  = 3'b000;
  localparam logic [2:0] OP_SKIP  = 3'b001;
  localparam logic [2:0] OP_JMP   = 3'b010;
  localparam logic [2:0] OP_LJMP  = 3'b011;
  localparam logic [2:0] OP_CALL  = 3'b100;
  localparam logic [2:0] OP_RET   = 3'b101;
  localparam logic [2:0] OP_RETSK = 3'b110;

  // One LFSR step of the low field; the page is carried through untouched.
  // All-ones PL is a fixed point with the default taps and is deliberately left so.
  function automatic logic [AW-1:0] step(input logic [AW-1:0] a);
    logic fb;
    fb = ~^(a[PL_W-1:0] & TAPS);
    return {a[AW-1:PL_W], fb, a[PL_W-1:1]};
  endfunction

  logic [AW-1:0]  stk    [DEPTH];
  logic [AW-1:0]  stk_nx [DEPTH];
  logic [AW-1:0]  pc_nx;
  logic [SPW-1:0] sp_nx;
  logic           ovf_set;
  logic           unf_set;
  logic           full;
  logic           empty;

  // Entries above sp_cnt are kept at zero, so entry 0 doubles as the popped value
  // and reads as zero on an empty stack.
  assign top   = stk[0];
  assign full  = (sp_cnt == SPW'(DEPTH));
  assign empty = (sp_cnt == '0);

  // Next-state for pc, stack and pointer, plus error events for this cycle.
  always_comb begin
    pc_nx   = pc;
    stk_nx  = stk;
    sp_nx   = sp_cnt;
    ovf_set = 1'b0;
    unf_set = 1'b0;
    if (en) begin
      case (op)
        OP_NEXT: pc_nx = step(pc);
        OP_SKIP: pc_nx = step(step(pc));
        OP_JMP:  pc_nx = {pc[AW-1:PL_W], tgt_pl};
        OP_LJMP: pc_nx = {tgt_pu, tgt_pl};
        OP_CALL: begin
          pc_nx = {CALL_PAGE, tgt_pl};
          if (full) begin
            ovf_set = 1'b1;
          end else begin
            sp_nx = sp_cnt + SPW'(1);
          end
          // In reject mode a full stack keeps its contents and the return address is dropped.
          if (!(full && OVF_MODE)) begin
            for (int i = DEPTH - 1; i > 0; i--) stk_nx[i] = stk[i-1];
            stk_nx[0] = step(pc);
          end
        end
        OP_RET, OP_RETSK: begin
          pc_nx = (op == OP_RETSK) ? step(stk[0]) : stk[0];
          if (empty) begin
            unf_set = 1'b1;
          end else begin
            sp_nx = sp_cnt - SPW'(1);
            for (int i = 0; i < DEPTH - 1; i++) stk_nx[i] = stk[i+1];
            stk_nx[DEPTH-1] = '0;
          end
        end
        default: ; // HOLD
      endcase
    end
  end

  // State registers; a new error in the same cycle as err_clr keeps its flag set.
  always_ff @(posedge CLK_main or posedge RESET) begin
    if (RESET) begin
      pc      <= '0;
      sp_cnt  <= '0;
      stk_ovf <= 1'b0;
      stk_unf <= 1'b0;
      for (int i = 0; i < DEPTH; i++) stk[i] <= '0;
    end else begin
      pc      <= pc_nx;
      sp_cnt  <= sp_nx;
      stk_ovf <= ovf_set | (stk_ovf & ~err_clr);
      stk_unf <= unf_set | (stk_unf & ~err_clr);
      for (int i = 0; i < DEPTH; i++) stk[i] <= stk_nx[i];
    end
  end

endmodule

// File: tb/tb_pc_stack_seq.sv
// Directed bench for pc_stack_seq with default parameters, plus a reject-mode
// instance driven by the same stimulus for the overflow-policy comparison.
module tb_pc_stack_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [2:0] op;
  logic [5:0] tgt_pl;
  logic [3:0] tgt_pu;
  logic       err_clr;

  logic [9:0] pc, top, pc1, top1;
  logic [2:0] sp_cnt, sp_cnt1;
  logic       stk_ovf, stk_unf, stk_ovf1, stk_unf1;

  int n_tests = 0;
  int n_fail  = 0;

  localparam logic [2:0] NEXT = 3'b000, SKIP = 3'b001, JMP = 3'b010, LJMP = 3'b011,
                         CALL = 3'b100, RET = 3'b101, RETSK = 3'b110, HOLD = 3'b111;

  always #5 clk = ~clk;

  pc_stack_seq u_dut (
    .CLK_main(clk), .RESET(rst), .en(en), .op(op), .tgt_pl(tgt_pl), .tgt_pu(tgt_pu),
    .err_clr(err_clr), .pc(pc), .top(top), .sp_cnt(sp_cnt), .stk_ovf(stk_ovf), .stk_unf(stk_unf)
  );

  pc_stack_seq #(.OVF_MODE(1'b1)) u_dut_rej (
    .CLK_main(clk), .RESET(rst), .en(en), .op(op), .tgt_pl(tgt_pl), .tgt_pu(tgt_pu),
    .err_clr(err_clr), .pc(pc1), .top(top1), .sp_cnt(sp_cnt1), .stk_ovf(stk_ovf1), .stk_unf(stk_unf1)
  );

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Apply one op across one rising edge; returns 1 time unit after that edge.
  task automatic do_op(input logic [2:0] o, input logic [5:0] tp, input logic [3:0] tu,
                       input logic e, input logic ec);
    @(negedge clk);
    op = o; tgt_pl = tp; tgt_pu = tu; en = e; err_clr = ec;
    @(posedge clk);
    #1;
  endtask

  logic [9:0] next_exp [6];
  logic [9:0] ret_exp  [4];
  logic [9:0] ret_exp1 [4];

  initial begin
    next_exp = '{10'h020, 10'h030, 10'h038, 10'h03C, 10'h03E, 10'h01F};
    ret_exp  = '{10'h3E2, 10'h3E1, 10'h3C1, 10'h3C0};
    ret_exp1 = '{10'h3E1, 10'h3C1, 10'h3C0, 10'h020};

    rst = 1'b1; en = 1'b0; op = HOLD; tgt_pl = '0; tgt_pu = '0; err_clr = 1'b0;
    #22;
    check("rst_pc", 16'(pc), 16'h000);
    check("rst_top", 16'(top), 16'h000);
    check("rst_sp", 16'(sp_cnt), 16'h0);
    check("rst_ovf", 16'(stk_ovf), 16'h0);
    check("rst_unf", 16'(stk_unf), 16'h0);
    @(negedge clk);
    rst = 1'b0;

    // LFSR walk from zero
    for (int i = 0; i < 6; i++) begin
      do_op(NEXT, 6'h00, 4'h0, 1'b1, 1'b0);
      check($sformatf("next%0d", i), 16'(pc), 16'(next_exp[i]));
    end

    // SKIP, JMP into the fixed point
    do_op(LJMP, 6'h00, 4'h0, 1'b1, 1'b0);
    check("ljmp0", 16'(pc), 16'h000);
    do_op(SKIP, 6'h00, 4'h0, 1'b1, 1'b0);
    check("skip", 16'(pc), 16'h030);
    do_op(JMP, 6'h3F, 4'h0, 1'b1, 1'b0);
    check("jmp3f", 16'(pc), 16'h03F);
    for (int i = 0; i < 3; i++) begin
      do_op(NEXT, 6'h00, 4'h0, 1'b1, 1'b0);
      check($sformatf("fixpt%0d", i), 16'(pc), 16'h03F);
    end

    // CALL/RET and CALL/RETSK
    do_op(LJMP, 6'h00, 4'h0, 1'b1, 1'b0);
    do_op(CALL, 6'h05, 4'h0, 1'b1, 1'b0);
    check("call_pc", 16'(pc), 16'h3C5);
    check("call_top", 16'(top), 16'h020);
    check("call_sp", 16'(sp_cnt), 16'h1);
    do_op(RET, 6'h00, 4'h0, 1'b1, 1'b0);
    check("ret_pc", 16'(pc), 16'h020);
    check("ret_sp", 16'(sp_cnt), 16'h0);
    check("ret_top", 16'(top), 16'h000);
    do_op(LJMP, 6'h00, 4'h0, 1'b1, 1'b0);
    do_op(CALL, 6'h05, 4'h0, 1'b1, 1'b0);
    do_op(RETSK, 6'h00, 4'h0, 1'b1, 1'b0);
    check("retsk_pc", 16'(pc), 16'h030);
    check("retsk_sp", 16'(sp_cnt), 16'h0);

    // Overflow: five back-to-back CALLs
    do_op(LJMP, 6'h00, 4'h0, 1'b1, 1'b0);
    for (int i = 1; i <= 5; i++) begin
      do_op(CALL, 6'(i), 4'h0, 1'b1, 1'b0);
      if (i == 4) begin
        check("call4_sp", 16'(sp_cnt), 16'h4);
        check("call4_ovf", 16'(stk_ovf), 16'h0);
      end
    end
    check("ovf_flag", 16'(stk_ovf), 16'h1);
    check("ovf_sp", 16'(sp_cnt), 16'h4);
    check("ovf_pc", 16'(pc), 16'h3C5);
    check("ovf_top", 16'(top), 16'h3E2);
    check("rej_flag", 16'(stk_ovf1), 16'h1);
    check("rej_sp", 16'(sp_cnt1), 16'h4);
    check("rej_pc", 16'(pc1), 16'h3C5);
    check("rej_top", 16'(top1), 16'h3E1);
    for (int i = 0; i < 4; i++) begin
      do_op(RET, 6'h00, 4'h0, 1'b1, 1'b0);
      check($sformatf("pop%0d", i), 16'(pc), 16'(ret_exp[i]));
      check($sformatf("rej_pop%0d", i), 16'(pc1), 16'(ret_exp1[i]));
    end
    check("pop_sp", 16'(sp_cnt), 16'h0);
    do_op(RET, 6'h00, 4'h0, 1'b1, 1'b0);
    check("unf_pc", 16'(pc), 16'h000);
    check("unf_flag", 16'(stk_unf), 16'h1);
    check("unf_sp", 16'(sp_cnt), 16'h0);

    // Error flag clearing
    do_op(RET, 6'h00, 4'h0, 1'b1, 1'b1);
    check("clr_unf_wins", 16'(stk_unf), 16'h1);
    check("clr_ovf", 16'(stk_ovf), 16'h0);
    do_op(HOLD, 6'h00, 4'h0, 1'b0, 1'b1);
    check("clr_unf", 16'(stk_unf), 16'h0);
    check("clr_ovf2", 16'(stk_ovf), 16'h0);

    // en=0 blocks CALL
    do_op(CALL, 6'h05, 4'h0, 1'b0, 1'b0);
    check("en0_pc", 16'(pc), 16'h000);
    check("en0_sp", 16'(sp_cnt), 16'h0);
    check("en0_top", 16'(top), 16'h000);

    // Asynchronous reset mid-sequence
    for (int i = 1; i <= 3; i++) do_op(CALL, 6'(i), 4'h0, 1'b1, 1'b0);
    check("pre_rst_sp", 16'(sp_cnt), 16'h3);
    rst = 1'b1;
    #1;
    check("arst_pc", 16'(pc), 16'h000);
    check("arst_sp", 16'(sp_cnt), 16'h0);
    check("arst_top", 16'(top), 16'h000);
    check("arst_ovf", 16'(stk_ovf), 16'h0);
    en = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    do_op(NEXT, 6'h00, 4'h0, 1'b1, 1'b0);
    check("post_rst_next", 16'(pc), 16'h020);
    do_op(RET, 6'h00, 4'h0, 1'b1, 1'b0);
    check("post_rst_stk_empty", 16'(pc), 16'h000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_stack_seq.md
# pc_stack_seq

Parametrised program-sequencing unit for the 4-bit controller family. It combines a polynomial (LFSR-stepped) low program counter, a page register and a hardware return-address stack of configurable depth. It adds skip, long jump, overflow/underflow detection and selectable overflow policy. It sits between the instruction decoder, which supplies `op`, targets and a step strobe, and the external ROM address bus.

## Interface
- `PL_W`, 6: width of the LFSR-stepped low PC field (PL).
- `PU_W`, 4: width of the page field (PU).
- `TAPS`, 6'b000011: PL feedback tap mask, width `PL_W`.
- `DEPTH`, 4: number of return-stack entries, at least 1.
- `CALL_PAGE`, all-ones: PU value loaded by CALL.
- `OVF_MODE`, 0: 0 = push onto a full stack discards the oldest entry; 1 = push onto a full stack is rejected.
- `CLK_main` input 1: single system clock; all state changes on its rising edge.
- `RESET` input 1: asynchronous, active-high reset.
- `en` input 1: instruction-step strobe. When low, all state holds.
- `op` input 3: 000 NEXT, 001 SKIP, 010 JMP, 011 LJMP, 100 CALL, 101 RET, 110 RETSK, 111 HOLD.
- `tgt_pl` input `PL_W`: jump or call target for the low field.
- `tgt_pu` input `PU_W`: LJMP page target.
- `err_clr` input 1: clears the sticky error flags.
- `pc` output `PU_W+PL_W`: {PU,PL}, the current ROM address.
- `top` output `PU_W+PL_W`: stack top entry; zero when the stack is empty.
- `sp_cnt` output clog2(DEPTH+1): number of valid stack entries.
- `stk_ovf` output 1: sticky overflow flag.
- `stk_unf` output 1: sticky underflow flag.

## Operation
- step(x) keeps PU and sets PL to {fb, PL[PL_W-1:1]}.
  - fb = XNOR-reduce(PL & TAPS).
  - PU is never incremented.
- With the default taps, PL all-ones is a fixed point of step(). This is intentional and is not corrected.
- Ops execute only when `en`=1:
  - NEXT: pc <= step(pc).
  - SKIP: pc <= step(step(pc)), computed in one cycle.
  - JMP: PL <= tgt_pl; PU unchanged.
  - LJMP: pc <= {tgt_pu, tgt_pl}.
  - CALL: push step(pc), then pc <= {CALL_PAGE, tgt_pl}.
  - RET: pc <= popped entry.
  - RETSK: pc <= step(popped entry).
  - HOLD: no change.
- The stack is a shift stack: entry 0 is the top, and push shifts all entries down one place.
- Push when sp_cnt<DEPTH: sp_cnt+1.
- Push when sp_cnt==DEPTH:
  - `stk_ovf` <= 1 and sp_cnt stays DEPTH.
  - OVF_MODE 0: the oldest entry is lost and the new entry is written.
  - OVF_MODE 1: the stack is left unchanged and the return address is lost.
  - In both modes the jump to the call target still happens.
- Pop when sp_cnt>0: shift up, bottom entry <= 0, sp_cnt-1.
- Pop when sp_cnt==0: the popped value is 0, so RET gives pc=0 and RETSK gives pc=step(0). Also `stk_unf` <= 1 and sp_cnt stays 0.
- `err_clr`: clears both flags. If an error occurs in the same cycle, setting the flag wins.
- `err_clr` acts regardless of `en`.
- Unused op encodings: none; all eight are defined.

## Timing
- Fully synchronous single-cycle unit.
- Effect of the op sampled at edge N is visible on `pc`, `top`, `sp_cnt` and the flags immediately after edge N.
- `top` and `sp_cnt` are registered state; no combinational path from `op` to any output.
- `en`=0: all outputs hold, including for CALL, RET and RETSK ops.
- RESET asserted, at any time including mid-sequence:
  - pc=0, every stack entry=0, sp_cnt=0, top=0, stk_ovf=0, stk_unf=0.
  - Outputs change immediately; no clock is needed.
- First op is accepted on the first rising edge after RESET deasserts.
- Back-to-back CALL/RET on consecutive cycles is fully supported, with no bubbles.

## Test plan
All scenarios use default parameters.
- Reset, then NEXT ×6 from pc=0x000 -> PL sequence 0x20, 0x30, 0x38, 0x3C, 0x3E, 0x1F. PU stays 0.
- pc=0x000, SKIP -> pc=0x030. Then load PL=0x3F with JMP, then NEXT ×3 -> pc stays 0x03F (fixed point).
- pc=0x000, CALL tgt_pl=0x05 -> pc=0x3C5, top=0x020, sp_cnt=1. Then RET -> pc=0x020, sp_cnt=0. Repeating with RETSK instead of RET -> pc=0x030.
- OVF_MODE 0: five CALLs with tgt_pl=1..5 -> stk_ovf=1 and sp_cnt=4 after the fifth. Four RETs then return the newest four addresses in LIFO order. A fifth RET -> pc=0x000 and stk_unf=1.
- OVF_MODE 1, same stimulus -> after the fifth CALL the stack still holds the first four return addresses and pc=0x3C5.
- Error flags and reset:
  - err_clr together with a simultaneous underflow RET -> stk_unf stays 1.
  - err_clr alone -> both flags 0.
  - RESET pulse mid-sequence with sp_cnt=3 -> all outputs 0 asynchronously.
  - en=0 with op=CALL -> no change.
